// File: rtl/ddr3_pix_pack.sv
// ddr3_pix_pack
//   Packs PIX_PER_WORD pixels, LSB-first, into CACHE_WIDTH-bit words and buffers
//   them in a word FIFO. The FIFO drains toward the DDR3 write stage whenever
//   that stage is ready. A line that ends mid-word is flushed as a zero-padded
//   partial word. A Vsync rising edge discards any partial word but keeps the
//   words already in the FIFO.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   Vsync        : frame sync; a rising edge starts a frame
//   Hsync        : line sync; accepted, not used
//   DE           : pixel valid
//   pix_data     : pixel, sampled when DE=1
//   wr_rdy       : downstream can accept a word this cycle
//   ddr3_din_en  : one-cycle strobe per output word
//   ddr3_din     : packed word, valid while ddr3_din_en=1
//   frame_start  : one-cycle pulse after a Vsync rising edge
//   fifo_level   : current FIFO occupancy
//   ovf          : sticky overflow flag, cleared only by rst
module ddr3_pix_pack #(
  parameter int PIX_WIDTH    = 32,
  parameter int PIX_PER_WORD = 4,
  parameter int CACHE_WIDTH  = 128,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Vsync,
  input  logic                          Hsync,
  input  logic                          DE,
  input  logic [PIX_WIDTH-1:0]          pix_data,
  input  logic                          wr_rdy,
  output logic                          ddr3_din_en,
  output logic [CACHE_WIDTH-1:0]        ddr3_din,
  output logic                          frame_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf
);

  localparam int CW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic unused_hsync;
  assign unused_hsync = Hsync;

  logic                   vsync_q;
  logic                   de_q;
  logic                   vs_rise;
  logic [CW-1:0]          pack_cnt;
  logic [CACHE_WIDTH-1:0] pack_word;
  logic [CACHE_WIDTH-1:0] pack_filled;
  logic                   pack_last;

  // Completed (or flushed) word, staged one cycle before entering the FIFO.
  logic                   wr_req;
  logic [CACHE_WIDTH-1:0] wr_data;

  logic [CACHE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   do_wr;
  logic                   do_pop;

  assign vs_rise   = Vsync & ~vsync_q;
  assign pack_last = (pack_cnt == CW'(PIX_PER_WORD - 1));

  always_comb begin
    pack_filled = pack_word;
    pack_filled[pack_cnt*PIX_WIDTH +: PIX_WIDTH] = pix_data;
  end

  // Packer. Vsync rise has priority: it drops the partial word and the pixel
  // on the same edge. Completed words leave pack_word cleared, so any later
  // partial flush is zero-padded in the unfilled slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
      frame_start <= 1'b0;
      pack_cnt    <= '0;
      pack_word   <= '0;
      wr_req      <= 1'b0;
      wr_data     <= '0;
    end else begin
      vsync_q     <= Vsync;
      de_q        <= DE;
      frame_start <= vs_rise;
      wr_req      <= 1'b0;
      if (vs_rise) begin
        pack_cnt  <= '0;
        pack_word <= '0;
      end else if (DE) begin
        if (pack_last) begin
          wr_req    <= 1'b1;
          wr_data   <= pack_filled;
          pack_cnt  <= '0;
          pack_word <= '0;
        end else begin
          pack_cnt  <= pack_cnt + CW'(1);
          pack_word <= pack_filled;
        end
      end else if (de_q && (pack_cnt != '0)) begin
        wr_req    <= 1'b1;
        wr_data   <= pack_word;
        pack_cnt  <= '0;
        pack_word <= '0;
      end
    end
  end

  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign do_pop     = wr_rdy & ~fifo_empty;
  // A pop frees the slot on the same edge, so a full FIFO still takes the word.
  assign do_wr      = wr_req & (~fifo_full | do_pop);

  // Storage is not reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      ovf         <= 1'b0;
      ddr3_din_en <= 1'b0;
      ddr3_din    <= '0;
    end else begin
      ddr3_din_en <= do_pop;
      if (do_pop) begin
        ddr3_din <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (wr_req && !do_wr) ovf <= 1'b1;
      case ({do_wr, do_pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_pix_pack.sv
// tb_ddr3_pix_pack
//   Directed bench for ddr3_pix_pack with default parameters. Inputs change
//   1 time unit after each rising edge; outputs are read at the same point or
//   captured on the falling edge.
module tb_ddr3_pix_pack;

  logic         clk;
  logic         rst;
  logic         Vsync;
  logic         Hsync;
  logic         DE;
  logic [31:0]  pix_data;
  logic         wr_rdy;
  logic         ddr3_din_en;
  logic [127:0] ddr3_din;
  logic         frame_start;
  logic [4:0]   fifo_level;
  logic         ovf;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int fs_cnt = 0;
  logic [127:0] cap_q [$];
  int           cap_cyc [$];

  ddr3_pix_pack dut (
    .clk         (clk),
    .rst         (rst),
    .Vsync       (Vsync),
    .Hsync       (Hsync),
    .DE          (DE),
    .pix_data    (pix_data),
    .wr_rdy      (wr_rdy),
    .ddr3_din_en (ddr3_din_en),
    .ddr3_din    (ddr3_din),
    .frame_start (frame_start),
    .fifo_level  (fifo_level),
    .ovf         (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ddr3_din_en) begin
      cap_q.push_back(ddr3_din);
      cap_cyc.push_back(cyc);
    end
    if (frame_start) fs_cnt++;
  end

  function automatic logic [127:0] pack4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] gen_pix(input int n, input int k);
    return 32'(n * 256 + k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    DE = 1'b0;
    pix_data = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_pix(input logic [31:0] v);
    DE = 1'b1;
    pix_data = v;
    tick();
  endtask

  task automatic send_words(input int first, input int count);
    for (int n = first; n < first + count; n++)
      for (int k = 0; k < 4; k++) send_pix(gen_pix(n, k));
  endtask

  task automatic clear_caps();
    cap_q.delete();
    cap_cyc.delete();
    fs_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    DE = 1'b0;
    Vsync = 1'b0;
    pix_data = '0;
    tick();
    rst = 1'b0;
    clear_caps();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (ddr3_din_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", ddr3_din_en); end
    checks++; if (ddr3_din !== 128'd0) begin errors++; $display("FAIL reset_din got=%h exp=0", ddr3_din); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst = 1'b0;
    clear_caps();
  endtask

  task automatic test_pack_full();
    int e0;
    logic [127:0] w1, w2;
    w1 = pack4(32'h1, 32'h2, 32'h3, 32'h4);
    w2 = pack4(32'h5, 32'h6, 32'h7, 32'h8);
    do_reset();
    wr_rdy = 1'b1;
    e0 = 0;
    for (int i = 1; i <= 8; i++) begin
      send_pix(32'(i));
      if (i == 4) e0 = cyc;
    end
    idle(8);
    checks++; if (cap_q.size() !== 2) begin errors++; $display("FAIL s1_count got=%0d exp=2", cap_q.size()); end
    if (cap_q.size() >= 2) begin
      checks++; if (cap_q[0] !== w1) begin errors++; $display("FAIL s1_word0 got=%h exp=%h", cap_q[0], w1); end
      checks++; if (cap_q[1] !== w2) begin errors++; $display("FAIL s1_word1 got=%h exp=%h", cap_q[1], w2); end
      checks++; if (cap_cyc[0] !== e0 + 2) begin errors++; $display("FAIL s1_latency got_edge=%0d exp_edge=%0d", cap_cyc[0], e0 + 2); end
    end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL s1_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_partial();
    logic [127:0] w1, w2;
    w1 = pack4(32'h11, 32'h12, 32'h13, 32'h14);
    w2 = pack4(32'h15, 32'h16, 32'h0, 32'h0);
    do_reset();
    wr_rdy = 1'b1;
    for (int i = 'h11; i <= 'h16; i++) send_pix(32'(i));
    idle(8);
    checks++; if (cap_q.size() !== 2) begin errors++; $display("FAIL s2_count got=%0d exp=2", cap_q.size()); end
    if (cap_q.size() >= 2) begin
      checks++; if (cap_q[0] !== w1) begin errors++; $display("FAIL s2_word0 got=%h exp=%h", cap_q[0], w1); end
      checks++; if (cap_q[1] !== w2) begin errors++; $display("FAIL s2_partial got=%h exp=%h", cap_q[1], w2); end
    end
  endtask

  task automatic test_overflow();
    logic [127:0] exp_w;
    do_reset();
    wr_rdy = 1'b0;
    send_words(1, 17);
    idle(4);
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL s3_level_full got=%0d exp=16", fifo_level); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL s3_ovf_set got=%b exp=1", ovf); end
    checks++; if (cap_q.size() !== 0) begin errors++; $display("FAIL s3_no_drain got=%0d exp=0", cap_q.size()); end
    wr_rdy = 1'b1;
    idle(24);
    checks++; if (cap_q.size() !== 16) begin errors++; $display("FAIL s3_count got=%0d exp=16", cap_q.size()); end
    for (int n = 1; n <= 16; n++) begin
      if (n <= cap_q.size()) begin
        exp_w = pack4(gen_pix(n, 0), gen_pix(n, 1), gen_pix(n, 2), gen_pix(n, 3));
        checks++; if (cap_q[n-1] !== exp_w) begin errors++; $display("FAIL s3_word%0d got=%h exp=%h", n, cap_q[n-1], exp_w); end
      end
    end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL s3_ovf_sticky got=%b exp=1", ovf); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL s3_level_empty got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_vsync();
    logic [127:0] w1;
    w1 = pack4(32'h1, 32'h2, 32'h3, 32'h4);
    do_reset();
    wr_rdy = 1'b1;
    send_pix(32'h55);
    send_pix(32'h66);
    Vsync = 1'b1;
    send_pix(32'hAA);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL s4_fs_high got=%b exp=1", frame_start); end
    for (int i = 1; i <= 4; i++) send_pix(32'(i));
    idle(6);
    Vsync = 1'b0;
    idle(2);
    checks++; if (fs_cnt !== 1) begin errors++; $display("FAIL s4_fs_cycles got=%0d exp=1", fs_cnt); end
    checks++; if (cap_q.size() !== 1) begin errors++; $display("FAIL s4_count got=%0d exp=1", cap_q.size()); end
    if (cap_q.size() >= 1) begin
      checks++; if (cap_q[0] !== w1) begin errors++; $display("FAIL s4_word got=%h exp=%h", cap_q[0], w1); end
    end
  endtask

  task automatic test_full_simul();
    logic [127:0] w17;
    w17 = pack4(gen_pix(17, 0), gen_pix(17, 1), gen_pix(17, 2), gen_pix(17, 3));
    do_reset();
    wr_rdy = 1'b0;
    send_words(1, 16);
    idle(3);
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL s5_level_pre got=%0d exp=16", fifo_level); end
    // Word 17 completes at E0; its FIFO write lands on E0+1 together with a pop.
    send_words(17, 1);
    wr_rdy = 1'b1;
    DE = 1'b0;
    tick();
    wr_rdy = 1'b0;
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL s5_level_same got=%0d exp=16", fifo_level); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL s5_ovf got=%b exp=0", ovf); end
    checks++; if (ddr3_din_en !== 1'b1) begin errors++; $display("FAIL s5_pop_en got=%b exp=1", ddr3_din_en); end
    wr_rdy = 1'b1;
    idle(22);
    checks++; if (cap_q.size() !== 17) begin errors++; $display("FAIL s5_count got=%0d exp=17", cap_q.size()); end
    if (cap_q.size() >= 17) begin
      checks++; if (cap_q[0] !== pack4(gen_pix(1, 0), gen_pix(1, 1), gen_pix(1, 2), gen_pix(1, 3))) begin errors++; $display("FAIL s5_first got=%h", cap_q[0]); end
      checks++; if (cap_q[16] !== w17) begin errors++; $display("FAIL s5_last got=%h exp=%h", cap_q[16], w17); end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] w1, wn;
    w1 = pack4(gen_pix(1, 0), gen_pix(1, 1), gen_pix(1, 2), gen_pix(1, 3));
    wn = pack4(32'h21, 32'h22, 32'h23, 32'h24);
    do_reset();
    wr_rdy = 1'b0;
    send_words(1, 6);
    wr_rdy = 1'b1;
    send_pix(32'hC1);
    wr_rdy = 1'b0;
    send_pix(32'hC2);
    checks++; if (fifo_level !== 5'd5) begin errors++; $display("FAIL s6_level_pre got=%0d exp=5", fifo_level); end
    checks++; if (ddr3_din !== w1) begin errors++; $display("FAIL s6_din_pre got=%h exp=%h", ddr3_din, w1); end
    rst = 1'b1;
    DE = 1'b0;
    wr_rdy = 1'b1;
    tick();
    rst = 1'b0;
    clear_caps();
    checks++; if (ddr3_din_en !== 1'b0) begin errors++; $display("FAIL s6_en got=%b exp=0", ddr3_din_en); end
    checks++; if (ddr3_din !== 128'd0) begin errors++; $display("FAIL s6_din got=%h exp=0", ddr3_din); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL s6_fs got=%b exp=0", frame_start); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL s6_level got=%0d exp=0", fifo_level); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL s6_ovf got=%b exp=0", ovf); end
    idle(10);
    checks++; if (cap_q.size() !== 0) begin errors++; $display("FAIL s6_quiet got=%0d exp=0", cap_q.size()); end
    for (int i = 'h21; i <= 'h24; i++) send_pix(32'(i));
    idle(8);
    checks++; if (cap_q.size() !== 1) begin errors++; $display("FAIL s6_count got=%0d exp=1", cap_q.size()); end
    if (cap_q.size() >= 1) begin
      checks++; if (cap_q[0] !== wn) begin errors++; $display("FAIL s6_word got=%h exp=%h", cap_q[0], wn); end
    end
  endtask

  initial begin
    rst = 1'b1;
    Vsync = 1'b0;
    Hsync = 1'b0;
    DE = 1'b0;
    pix_data = '0;
    wr_rdy = 1'b0;
    test_reset();
    test_pack_full();
    test_partial();
    test_overflow();
    test_vsync();
    test_full_simul();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr3_pix_pack.md
DDR3_PIX_PACK -- requirements
Module: ddr3_pix_pack

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PIX_WIDTH, 32, bits per input pixel.
- PIX_PER_WORD, 4, pixels packed per output word.
- CACHE_WIDTH, 128, output word width; SHALL equal PIX_WIDTH*PIX_PER_WORD.
- FIFO_DEPTH, 16, word FIFO depth; SHALL be a power of 2.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock; all logic on the rising edge.
- rst, in, 1, synchronous active-high reset.
- Vsync, in, 1, frame sync; its rising edge starts a frame.
- Hsync, in, 1, line sync; accepted but functionally unused.
- DE, in, 1, pixel valid.
- pix_data, in, PIX_WIDTH, pixel, sampled when DE=1.
- wr_rdy, in, 1, downstream write stage can take a word this cycle.
- ddr3_din_en, out, 1, one-cycle strobe per output word.
- ddr3_din, out, CACHE_WIDTH, packed word, valid while ddr3_din_en=1.
- frame_start, out, 1, one-cycle pulse on Vsync rising edge.
- fifo_level, out, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- ovf, out, 1, sticky overflow flag.

Function
REQ-003 Packing SHALL be LSB-first: the k-th pixel of a word (k=0..PIX_PER_WORD-1) occupies bits [(k+1)*PIX_WIDTH-1 : k*PIX_WIDTH].
REQ-004 A pack counter (0..PIX_PER_WORD-1) SHALL advance on each edge with DE=1 and wrap to 0 when the word completes.
REQ-005 When the last pixel of a word is sampled at edge E0, the word SHALL be written into the FIFO at edge E0+1.
REQ-006 On a DE falling edge (DE=0 with the registered DE=1) and a non-zero pack counter, the partial word SHALL be written with unfilled pixel slots zero, and the counter SHALL clear.
REQ-007 Vsync rising detection SHALL use the registered Vsync, which resets to 0.
REQ-008 On a detected Vsync rise:
- frame_start SHALL be 1 for exactly one cycle.
- The pack counter and partial word SHALL clear without a FIFO write.
- A pixel presented with DE=1 on that same edge SHALL be discarded.
- FIFO contents SHALL be kept.
REQ-009 On any edge where the FIFO is non-empty and wr_rdy=1, the FIFO head SHALL be popped into the ddr3_din register and ddr3_din_en SHALL be 1 for the next cycle; otherwise ddr3_din_en SHALL be 0 and ddr3_din SHALL hold its value.
REQ-010 Minimum latency, with wr_rdy=1 and the FIFO empty: ddr3_din_en SHALL rise after edge E0+2 for a word completed at E0.
REQ-011 A write and a pop on the same edge SHALL both occur, including when the FIFO is full; fifo_level SHALL then be unchanged and ovf SHALL not set.
REQ-012 A write to a full FIFO without a simultaneous pop SHALL drop the new word, leave the contents unchanged, and set ovf.
REQ-013 ovf SHALL clear only on rst.
REQ-014 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-015 fifo_level SHALL equal writes minus pops, within 0..FIFO_DEPTH, and SHALL update on the same edge as the write or pop.
REQ-016 Words SHALL leave in write order, with no reordering or duplication.

Reset
REQ-017 While rst=1 at an edge, the block SHALL set:
- ddr3_din_en=0, ddr3_din=0, frame_start=0, fifo_level=0, ovf=0;
- pack counter=0, partial word=0, FIFO pointers=0;
- registered Vsync=0 and registered DE=0.
REQ-018 rst asserted mid-frame or mid-word SHALL discard all buffered and partial data, and no ddr3_din_en SHALL occur until new words are packed after rst deasserts.

Verification
REQ-019 Scenario 1: 8 pixels 0x01..0x08 with DE=1 continuously and wr_rdy=1 -> two ddr3_din_en pulses with ddr3_din=0x00000004_00000003_00000002_00000001 then 0x00000008_00000007_00000006_00000005; the first pulse rises after edge E0+2 of pixel 0x04.
REQ-020 Scenario 2: 6 pixels 0x11..0x16 then DE=0 -> second word is 0x00000000_00000000_00000016_00000015.
REQ-021 Scenario 3: wr_rdy=0 while 17 words are packed -> fifo_level=16 and ovf=1, word 17 is absent; then wr_rdy=1 -> exactly 16 pulses carrying words 1..16 in order, with ovf still 1.
REQ-022 Scenario 4: 2 pixels, then a Vsync rise coinciding with DE=1 and pixel 0xAA, then pixels 0x01..0x04 -> frame_start pulses once, 0xAA and the 2 earlier pixels never appear, and the next word is 0x00000004_00000003_00000002_00000001.
REQ-023 Scenario 5: FIFO full with wr_rdy=1 and a word write on the same edge -> fifo_level stays 16 and ovf stays 0.
REQ-024 Scenario 6: rst=1 for one edge with fifo_level=5 and a half-packed word -> after that edge, all outputs are 0 and no ddr3_din_en pulse occurs before new complete words.
